// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store/fill request sequencer in front of a single-port data memory
module mem_access_ctrl #(
    parameter int AW   = 19,
    parameter int DW   = 19,
    parameter int LENW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_data,
    input  logic [LENW-1:0] req_len,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [DW-1:0]   resp_data,
    output logic            busy,
    output logic            err,
    output logic [AW-1:0]   mem_address,
    output logic [DW-1:0]   mem_write_data,
    output logic            mem_write,
    input  logic [DW-1:0]   mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RESP,
        S_STORE,
        S_FILL
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;

    state_t          state_q, state_d;
    logic [AW-1:0]   mem_address_q, mem_address_d;
    logic [DW-1:0]   mem_write_data_q, mem_write_data_d;
    logic            mem_write_q, mem_write_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_data_q, resp_data_d;
    logic            err_q, err_d;
    logic            req_ready_q, req_ready_d;

    // mem_address_q doubles as the working address, so the pins only ever change from flops
    always_comb begin
        state_d          = state_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        mem_write_d      = mem_write_q;
        cnt_d            = cnt_q;
        resp_valid_d     = resp_valid_q;
        resp_data_d      = resp_data_q;
        err_d            = 1'b0;

        case (state_q)
            S_IDLE: begin
                mem_write_d = 1'b0;
                if (req_valid && req_ready_q) begin
                    case (req_op)
                        OP_LOAD: begin
                            state_d       = S_LOAD;
                            mem_address_d = req_addr;
                        end
                        OP_STORE: begin
                            state_d          = S_STORE;
                            mem_address_d    = req_addr;
                            mem_write_data_d = req_data;
                            mem_write_d      = 1'b1;
                        end
                        OP_FILL: begin
                            if (req_len != '0) begin
                                state_d          = S_FILL;
                                mem_address_d    = req_addr;
                                mem_write_data_d = req_data;
                                mem_write_d      = 1'b1;
                                cnt_d            = req_len;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                resp_data_d  = mem_read_data;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_STORE: begin
                mem_write_d = 1'b0;
                state_d     = S_IDLE;
            end
            S_FILL: begin
                if (cnt_q == LENW'(1)) begin
                    mem_write_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    mem_address_d = mem_address_q + AW'(1);
                    cnt_d         = cnt_q - LENW'(1);
                end
            end
            default: begin
                mem_write_d  = 1'b0;
                resp_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_write_q      <= 1'b0;
            cnt_q            <= '0;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= '0;
            err_q            <= 1'b0;
            req_ready_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_write_q      <= mem_write_d;
            cnt_q            <= cnt_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            err_q            <= err_d;
            req_ready_q      <= req_ready_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign busy           = (state_q != S_IDLE);
    assign err            = err_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_write      = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a reference memory model
module tb_mem_access_ctrl;

    localparam int AW   = 19;
    localparam int DW   = 19;
    localparam int LENW = 8;
    localparam int MEMN = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_data;
    logic [LENW-1:0] req_len;
    logic            resp_valid;
    logic            resp_ready;
    logic [DW-1:0]   resp_data;
    logic            busy;
    logic            err;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_write_data;
    logic            mem_write;
    logic [DW-1:0]   mem_read_data;

    logic rr_en = 1'b0;
    logic rr_rand = 1'b1;
    logic rr_dir = 1'b1;
    assign resp_ready = rr_en ? rr_rand : rr_dir;

    always #5 clk = ~clk;

    mem_access_ctrl #(.AW(AW), .DW(DW), .LENW(LENW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_len        (req_len),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .busy           (busy),
        .err            (err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    logic [DW-1:0] mem [0:MEMN-1];
    always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;
    assign mem_read_data = mem[mem_address];

    logic [DW-1:0]    ref_mem [int];
    int               written[$];
    logic [DW-1:0]    exp_resp[$];
    logic [AW+DW-1:0] exp_wr[$];
    int               exp_err = 0;
    int               wr_count = 0;
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic void model_write(input int a, input logic [DW-1:0] d);
        logic [AW-1:0] aa;
        aa = AW'(a % MEMN);
        exp_wr.push_back({aa, d});
        if (!ref_mem.exists(int'(aa))) written.push_back(int'(aa));
        ref_mem[int'(aa)] = d;
    endfunction

    always @(negedge clk) begin : monitor
        logic [AW+DW-1:0] e;
        if (rst_n) begin
            if (resp_valid && resp_ready) begin
                if (exp_resp.size() == 0) check("resp_unexpected", resp_valid, 1'b0);
                else check("resp_data", resp_data, exp_resp.pop_front());
            end
            if (mem_write) begin
                wr_count++;
                if (exp_wr.size() == 0) check("write_unexpected", mem_write, 1'b0);
                else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", mem_address, e[AW+DW-1:DW]);
                    check("wr_data", mem_write_data, e[DW-1:0]);
                end
            end
            if (err) begin
                if (exp_err == 0) check("err_unexpected", err, 1'b0);
                else exp_err--;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rr_rand = ($urandom_range(0, 2) != 0);
    end

    // nwr lets a fill expect fewer writes than its length when reset will cut it short
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [LENW-1:0] len, input int nwr);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", req_ready, 1'b1);
            return;
        end
        case (op)
            2'b00: exp_resp.push_back(rd(int'(a)));
            2'b01: model_write(int'(a), d);
            2'b10: for (int i = 0; i < nwr; i++) model_write(int'(a) + i, d);
            default: exp_err++;
        endcase
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        req_len   = len;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = AW'($urandom);
        req_data  = DW'($urandom);
        req_len   = LENW'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_resp.size() != 0 || exp_wr.size() != 0 || exp_err != 0 || busy) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_busy", busy, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] addr_before;
        logic [1:0]    op;
        logic [LENW-1:0] len;
        int            wc0;

        rst_n = 1'b0;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0; req_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", req_ready, 1'b1);

        // store then load with response held off for five cycles
        issue(2'b01, 19'h00010, 19'h12345, '0, 0);
        rr_dir = 1'b0;
        issue(2'b00, 19'h00010, '0, '0, 0);
        @(negedge clk);
        check("load_lat_t1_valid", resp_valid, 1'b0);
        check("load_lat_t1_busy", busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_resp_valid", resp_valid, 1'b1);
            check("hold_resp_data", resp_data, 19'h12345);
            check("hold_req_ready", req_ready, 1'b0);
        end
        @(posedge clk); #1;
        rr_dir = 1'b1;
        drain();

        // fill crossing the top of the address space
        wc0 = wr_count;
        issue(2'b10, 19'h7FFFE, 19'h00AAA, 8'd4, 4);
        drain();
        check("fill_wr_count", wr_count - wc0, 4);
        check("fill_w0", mem[19'h7FFFE], 19'h00AAA);
        check("fill_w1", mem[19'h7FFFF], 19'h00AAA);
        check("fill_w2", mem[19'h00000], 19'h00AAA);
        check("fill_w3", mem[19'h00001], 19'h00AAA);

        // zero-length fill
        wc0 = wr_count;
        issue(2'b10, 19'h00100, 19'h00005, 8'd0, 0);
        check("len0_ready", req_ready, 1'b1);
        check("len0_busy", busy, 1'b0);
        @(negedge clk);
        check("len0_wr_count", wr_count - wc0, 0);

        // illegal op
        addr_before = mem_address;
        issue(2'b11, 19'h05555, 19'h1ABCD, 8'd3, 0);
        @(negedge clk);
        check("err_pulse", err, 1'b1);
        check("err_no_write", mem_write, 1'b0);
        @(negedge clk);
        check("err_one_cycle", err, 1'b0);
        check("err_addr_held", mem_address, addr_before);

        // randomized traffic
        rr_en = 1'b1;
        for (int k = 0; k < 80; k++) begin
            op  = 2'($urandom_range(0, 3));
            len = LENW'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) a = AW'(MEMN - 8 + $urandom_range(0, 7));
            else a = AW'($urandom_range(0, 63));
            if (op == 2'b00) begin
                if (written.size() == 0) op = 2'b01;
                else a = AW'(written[$urandom_range(0, written.size() - 1)]);
            end
            issue(op, a, DW'($urandom), len, int'(len));
        end
        drain();
        rr_en = 1'b0;

        // reset during the third word of a ten-word fill
        issue(2'b01, 19'h00202, 19'h01111, '0, 0);
        drain();
        wc0 = wr_count;
        issue(2'b10, 19'h00200, 19'h3C3C3, 8'd10, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midfill_mem_write", mem_write, 1'b0);
        check("midfill_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("midfill_wr_count", wr_count - wc0, 2);
        check("midfill_w0", mem[19'h00200], 19'h3C3C3);
        check("midfill_w1", mem[19'h00201], 19'h3C3C3);
        check("midfill_w2", mem[19'h00202], rd(32'h202));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midfill_ready", req_ready, 1'b1);

        // reset while a response is pending
        rr_dir = 1'b0;
        issue(2'b00, 19'h00010, '0, '0, 0);
        repeat (3) @(negedge clk);
        check("midresp_valid", resp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midresp_dropped", resp_valid, 1'b0);
        exp_resp.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rr_dir = 1'b1;
        repeat (3) @(negedge clk);
        check("midresp_stays_low", resp_valid, 1'b0);

        check("pending_resp", exp_resp.size(), 0);
        check("pending_wr", exp_wr.size(), 0);
        check("pending_err", exp_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
